// File: rtl/oddr_tlvds_tx_sched_if.sv
// Requester-side handshake bundle for oddr_tlvds_tx_sched: two valid/ready word channels.
// master = frame producers, slave = scheduler.
interface oddr_tlvds_tx_sched_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_last;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_last;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/oddr_tlvds_tx_sched.sv
// Two-requester frame scheduler driving ODDR D0/D1/TX for a TLVDS_TBUF output.
// Frame: warm-up, data pairs, parity pair (ODDR_TX_SCHED_PARITY_EN), guard, release.
module oddr_tlvds_tx_sched #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WARMUP = 4,
  parameter int unsigned GUARD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  oddr_tlvds_tx_sched_if.slave  req,
  output logic                  oddr_d0,
  output logic                  oddr_d1,
  output logic                  oddr_tx,
  output logic                  grant,
  output logic                  busy,
  output logic                  underrun
);

  localparam int unsigned Half     = WIDTH / 2;
  localparam int unsigned PairW    = (Half > 1) ? $clog2(Half) : 1;
  localparam int unsigned PhaseMax = (WARMUP > GUARD) ? WARMUP : GUARD;
  localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;

  localparam logic [PairW-1:0]  PairLast  = PairW'(Half - 1);
  localparam logic [PhaseW-1:0] WarmLast  = PhaseW'(WARMUP - 1);
  localparam logic [PhaseW-1:0] GuardLast = PhaseW'(GUARD - 1);

`ifdef ODDR_TX_SCHED_PARITY_EN
  typedef enum logic [2:0] {StIdle, StWarm, StData, StPar, StGuard} state_e;
  logic par_q;
`else
  typedef enum logic [1:0] {StIdle, StWarm, StData, StGuard} state_e;
`endif

  state_e           state_q;
  logic [PairW-1:0] pair_q;
  logic [PhaseW-1:0] phase_q;
  logic [WIDTH-1:0] shift_q;
  logic             last_q;
  logic             fill_q;
  logic             rr_q;

  logic             own_valid;
  logic [WIDTH-1:0] own_data;
  logic             own_last;
  logic             load_win;

  always_comb begin
    own_valid = req.req0_valid;
    own_data  = req.req0_data;
    own_last  = req.req0_last;
    if (grant) begin
      own_valid = req.req1_valid;
      own_data  = req.req1_data;
      own_last  = req.req1_last;
    end
  end

  // Load points: last warm-up clk, final pair of a non-last word, and every underrun fill clk.
  assign load_win = (state_q == StWarm && phase_q == WarmLast) ||
                    (state_q == StData && (fill_q || (pair_q == PairLast && !last_q)));

  assign req.req0_ready = load_win && !grant;
  assign req.req1_ready = load_win && grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      oddr_tx  <= 1'b1;
      oddr_d0  <= 1'b0;
      oddr_d1  <= 1'b0;
      grant    <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
      rr_q     <= 1'b0;
      pair_q   <= '0;
      phase_q  <= '0;
      shift_q  <= '0;
      last_q   <= 1'b0;
      fill_q   <= 1'b0;
`ifdef ODDR_TX_SCHED_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      underrun <= 1'b0;
      if (load_win) begin
        state_q <= StData;
        pair_q  <= '0;
        if (own_valid) begin
          oddr_d0 <= own_data[0];
          oddr_d1 <= own_data[1];
          shift_q <= own_data >> 2;
          last_q  <= own_last;
          fill_q  <= 1'b0;
`ifdef ODDR_TX_SCHED_PARITY_EN
          par_q   <= par_q ^ (^own_data);
`endif
        end else begin
          // Hold the line driven with zero pairs; pulse only on entry to the fill run.
          oddr_d0  <= 1'b0;
          oddr_d1  <= 1'b0;
          fill_q   <= 1'b1;
          underrun <= !fill_q;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            oddr_tx <= 1'b1;
            oddr_d0 <= 1'b0;
            oddr_d1 <= 1'b0;
            busy    <= 1'b0;
`ifdef ODDR_TX_SCHED_PARITY_EN
            par_q   <= 1'b0;
`endif
            if (req.req0_valid || req.req1_valid) begin
              grant   <= (req.req0_valid && req.req1_valid) ? rr_q : req.req1_valid;
              busy    <= 1'b1;
              oddr_tx <= 1'b0;
              oddr_d1 <= 1'b1;
              phase_q <= '0;
              state_q <= StWarm;
            end
          end
          StWarm: phase_q <= phase_q + PhaseW'(1);
          StData: begin
            if (pair_q == PairLast) begin
              phase_q <= '0;
`ifdef ODDR_TX_SCHED_PARITY_EN
              oddr_d0 <= par_q;
              oddr_d1 <= ~par_q;
              state_q <= StPar;
`else
              oddr_d0 <= 1'b0;
              oddr_d1 <= 1'b1;
              state_q <= StGuard;
`endif
            end else begin
              oddr_d0 <= shift_q[0];
              oddr_d1 <= shift_q[1];
              shift_q <= shift_q >> 2;
              pair_q  <= pair_q + PairW'(1);
            end
          end
`ifdef ODDR_TX_SCHED_PARITY_EN
          StPar: begin
            oddr_d0 <= 1'b0;
            oddr_d1 <= 1'b1;
            phase_q <= '0;
            state_q <= StGuard;
          end
`endif
          StGuard: begin
            if (phase_q == GuardLast) begin
              oddr_tx <= 1'b1;
              oddr_d0 <= 1'b0;
              oddr_d1 <= 1'b0;
              busy    <= 1'b0;
              rr_q    <= ~grant;
              state_q <= StIdle;
            end else begin
              phase_q <= phase_q + PhaseW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oddr_tlvds_tx_sched.sv
// Self-checking bench for oddr_tlvds_tx_sched: directed and random frames against a
// frame-level model of the expected line sequence.
module tb_oddr_tlvds_tx_sched;
  localparam int unsigned W      = 8;
  localparam int unsigned WARMUP = 4;
  localparam int unsigned GUARD  = 2;
  localparam int unsigned HALF   = W / 2;

  logic clk;
  logic rst;
  logic oddr_d0, oddr_d1, oddr_tx, grant, busy, underrun;

  oddr_tlvds_tx_sched_if #(.WIDTH(W)) bus ();

  oddr_tlvds_tx_sched #(
    .WIDTH  (W),
    .WARMUP (WARMUP),
    .GUARD  (GUARD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus),
    .oddr_d0  (oddr_d0),
    .oddr_d1  (oddr_d1),
    .oddr_tx  (oddr_tx),
    .grant    (grant),
    .busy     (busy),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;
  logic [W-1:0] fq[$];
  int           gq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [W-1:0] d, input logic l);
    if (r == 0) begin
      bus.req0_valid = v;
      bus.req0_data  = d;
      bus.req0_last  = l;
    end else begin
      bus.req1_valid = v;
      bus.req1_data  = d;
      bus.req1_last  = l;
    end
  endtask

  function automatic logic rdy(input int r);
    return (r == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic [4:0] line_now();
    return {oddr_tx, oddr_d0, oddr_d1, busy, underrun};
  endfunction

  // Plays one frame from fq/gq (gq[w] = load points the owner skips before word w).
  // Entry and exit: at a negedge with the DUT idle.
  task automatic run_frame(input logic [1:0] mask);
    int         win;
    int         oth;
    int         idx;
    int         gap_left;
    int         exp_ready;
    int         got_ready;
    logic       took;
    logic       p;
    logic [4:0] expq[$];

    win = (mask == 2'b11) ? rr_m : (mask[1] ? 1 : 0);
    oth = 1 - win;
    expq = {};
    p = 1'b0;
    exp_ready = 0;
    for (int i = 0; i < int'(WARMUP); i++) expq.push_back(5'b00110);
    for (int w = 0; w < fq.size(); w++) begin
      for (int g = 0; g < gq[w]; g++) expq.push_back({4'b0001, (g == 0)});
      for (int k = 0; k < int'(HALF); k++)
        expq.push_back({1'b0, fq[w][2*k], fq[w][2*k+1], 2'b10});
      p ^= ^fq[w];
      exp_ready += gq[w] + 1;
    end
`ifdef ODDR_TX_SCHED_PARITY_EN
    expq.push_back({1'b0, p, ~p, 2'b10});
`endif
    for (int i = 0; i < int'(GUARD); i++) expq.push_back(5'b00110);
    expq.push_back(5'b10000);

    idx = 0;
    gap_left = gq[0];
    took = 1'b0;
    got_ready = 0;
    set_req(win, 1'b1, fq[0], fq.size() == 1);
    set_req(oth, mask[oth], W'($urandom), 1'($urandom));

    for (int c = 0; c < expq.size(); c++) begin
      @(posedge clk);
      if (took) begin
        idx++;
        gap_left = (idx < fq.size()) ? gq[idx] : 0;
      end
      @(negedge clk);
      chk($sformatf("line[%0d]", c), 32'(line_now()), 32'(expq[c]));
      chk("grant", 32'(grant), 32'(win));
      chk("nonowner_ready", 32'(rdy(oth)), 32'd0);
      took = 1'b0;
      if (rdy(win)) begin
        got_ready++;
        if (gap_left > 0) begin
          gap_left--;
          set_req(win, 1'b0, W'($urandom), 1'b0);
        end else if (idx < fq.size()) begin
          set_req(win, 1'b1, fq[idx], idx == fq.size() - 1);
          took = 1'b1;
        end else begin
          set_req(win, 1'b0, '0, 1'b0);
        end
      end else if (idx < fq.size()) begin
        set_req(win, 1'b1, fq[idx], idx == fq.size() - 1);
      end else begin
        set_req(win, 1'b0, '0, 1'b0);
      end
      if (mask[oth]) set_req(oth, 1'b1, W'($urandom), 1'($urandom));
    end
    set_req(0, 1'b0, '0, 1'b0);
    set_req(1, 1'b0, '0, 1'b0);
    chk("ready_count", 32'(got_ready), 32'(exp_ready));
    chk("words_taken", 32'(idx), 32'(fq.size()));
    rr_m = oth;
  endtask

  initial begin
    logic [W-1:0] w;
    logic [4:0]   e;

    // Reset held 3 clks with both requesters valid.
    rst = 1'b1;
    set_req(0, 1'b1, 8'h3C, 1'b1);
    set_req(1, 1'b1, 8'hC3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("reset_line", 32'(line_now()), 32'b10000);
      chk("reset_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    end
    rst = 1'b0;
    set_req(0, 1'b0, '0, 1'b0);
    set_req(1, 1'b0, '0, 1'b0);

    // Contention: winners alternate 0, 1, 0.
    for (int f = 0; f < 3; f++) begin
      fq = {W'($urandom)};
      gq = {0};
      run_frame(2'b11);
    end

    // Single frame, streaming, underrun, parity-sensitive word.
    fq = {8'hA5};             gq = {0};       run_frame(2'b01);
    fq = {8'h00, 8'hFF, 8'h0F}; gq = {0, 0, 0}; run_frame(2'b01);
    fq = {8'h5A, 8'h96};      gq = {0, 2};    run_frame(2'b01);
    fq = {8'h07};             gq = {0};       run_frame(2'b10);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(1, 3);
      fq = {};
      gq = {};
      for (int i = 0; i < n; i++) begin
        fq.push_back(W'($urandom));
        gq.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      run_frame(2'($urandom_range(1, 3)));
    end

    // Reset while pair 2 of the data word is on the line.
    w = 8'hC3;
    set_req(0, 1'b1, w, 1'b1);
    for (int c = 0; c < int'(WARMUP) + 3; c++) begin
      @(negedge clk);
      if (c < int'(WARMUP)) e = 5'b00110;
      else e = {1'b0, w[2*(c-WARMUP)], w[2*(c-WARMUP)+1], 2'b10};
      chk($sformatf("prereset[%0d]", c), 32'(line_now()), 32'(e));
    end
    rst = 1'b1;
    set_req(0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("midreset_line", 32'(line_now()), 32'b10000);
    chk("midreset_grant", 32'(grant), 32'd0);
    chk("midreset_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    rst = 1'b0;
    rr_m = 0;
    fq = {w};
    gq = {0};
    run_frame(2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
